pattern_scan_scheduler: RTL
===========================

Name: pattern_scan_scheduler

Overview:
Job-level controller that sequences a serial target-pattern matcher. It accepts a scan job over a valid/ready handshake: a target pattern, a data word and a bit count. It then programs the matcher with the target and streams the data bits into it, one per cycle. It counts overlapping matches and returns a result over a second valid/ready handshake. It sits between a software-visible job queue and the bit-serial match datapath, and replaces direct reset-based reprogramming of the matcher.

Parameters:
TARGET_WIDTH, 5, pattern width in bits; legal range 2..DATA_WIDTH.
DATA_WIDTH, 32, maximum bits per job.
CNT_WIDTH, $clog2(DATA_WIDTH+1), width of length, count and index fields.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
job_valid  input  1  job offered.
job_ready  output  1  scheduler can accept a job.
job_target  input  TARGET_WIDTH  pattern; bit TARGET_WIDTH-1 is the oldest bit, bit 0 the newest.
job_data  input  DATA_WIDTH  bits to stream, LSB first.
job_len  input  CNT_WIDTH  number of bits to stream.
abort  input  1  drop the current job without producing a result.
res_valid  output  1  result available.
res_ready  input  1  result consumer ready.
res_count  output  CNT_WIDTH  number of matches, overlapping matches included.
res_hit  output  1  at least one match.
res_first  output  CNT_WIDTH  stream index (0-based) of the bit that completed the first match; 0 if no match.
busy  output  1  state is not S_IDLE.

Behaviour:
- Reset values: job_ready=1, res_valid=0, res_count=0, res_hit=0, res_first=0, busy=0, state S_IDLE. The window, fill counter, bit index and latched job are all cleared.
- State S_IDLE:
  - job_ready=1.
  - On job_valid&&job_ready: latch target and data; clear window and fill counter; set bit index to 0.
  - len_eff = min(job_len, DATA_WIDTH).
  - If len_eff==0, go to S_DONE; otherwise go to S_SCAN.
- State S_SCAN, one bit per cycle:
  - Stream bit = data[idx]; new window = {window[TARGET_WIDTH-2:0], bit}.
  - Fill counter increments and saturates at TARGET_WIDTH.
  - Match condition: new window == target AND (fill + 1) >= TARGET_WIDTH. The fill guard prevents matches on zero-initialised window contents.
  - On a match: res_count += 1; if res_hit==0, set res_first=idx and res_hit=1.
  - When idx == len_eff-1, go to S_DONE.
- State S_DONE:
  - res_valid=1. res_* outputs are held stable while res_ready=0.
  - On res_ready, go to S_IDLE. The result registers keep their values until the next accept, which clears them.
- Latency: accept in cycle 0; bits stream in cycles 1..len_eff; res_valid is first high in cycle len_eff+1. A new job can be accepted in the cycle after the result handshake; results are never back-to-back with accept.
- abort:
  - In S_SCAN or S_DONE, go to S_IDLE on the next cycle with res_valid=0 and no result emitted.
  - Ignored in S_IDLE; abort has priority over job accept.
  - Simultaneous abort and res_ready in S_DONE: treated as a completed handshake.
- job_ready is low in S_SCAN and S_DONE; job_valid is ignored there and job inputs are not sampled.
- Reset mid-operation: any in-flight job is discarded; state after reset is exactly the reset state; the next job sees no residual window bits.
- Maximum count is DATA_WIDTH-TARGET_WIDTH+1, which fits in CNT_WIDTH; no saturation is needed.

Decomposition:
- Package pattern_scan_pkg:
  - state enum typedef (S_IDLE, S_SCAN, S_DONE);
  - scan_result_t struct typedef (count, hit, first).
- One sub-module, pattern_window_matcher:
  - ports: clk, reset, clear, load_target, target, shift_en, bit_in, match;
  - contains the shift window, fill counter and comparator; match is combinational on the post-shift window.
- The scheduler holds the FSM, bit index, length clamp, result registers and both handshakes.

Test Plan:
- target=5'b10110, data=0x0000000D, len=5 -> res_valid in cycle 6 after accept; count=1, hit=1, first=4.
- target=5'b11111, data=0x0000007F, len=7 -> count=3, hit=1, first=4 (overlapping matches counted).
- target=5'b00000, data=0, len=4 -> count=0, hit=0, first=0 (fill guard). Same job with len=8 -> count=4, first=4.
- Result backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_* stable, job_ready=0, a pending second job is not accepted. Raise res_ready -> second job accepted in the following cycle.
- Reset asserted for one cycle after 3 streamed bits -> next cycle res_valid=0, job_ready=1, busy=0. Rerunning test 1 gives the same result.
- Length and abort edges:
  - len=0 -> res_valid in cycle 1, count=0, hit=0.
  - len=40 -> clamped to 32, res_valid in cycle 33.
  - abort in the 2nd S_SCAN cycle -> S_IDLE next cycle, no res_valid pulse.

Source files
------------

// File: rtl/pattern_scan_scheduler_pkg.sv
// Shared types for the pattern scan scheduler: FSM state encoding and result payload.
package pattern_scan_pkg;

  localparam int unsigned DEF_TARGET_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_CNT_WIDTH    = $clog2(DEF_DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Result payload; field widths follow the default configuration.
  typedef struct packed {
    logic [DEF_CNT_WIDTH-1:0] count;
    logic                     hit;
    logic [DEF_CNT_WIDTH-1:0] first;
  } scan_result_t;

endpackage

// File: rtl/pattern_scan_scheduler_if.sv
// Job and result handshakes between the job queue and the scan scheduler.
interface pattern_scan_scheduler_if #(
  parameter int unsigned TARGET_WIDTH = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH    = $clog2(DATA_WIDTH + 1)
);
  logic                    job_valid;
  logic                    job_ready;
  logic [TARGET_WIDTH-1:0] job_target;
  logic [DATA_WIDTH-1:0]   job_data;
  logic [CNT_WIDTH-1:0]    job_len;
  logic                    abort;
  logic                    res_valid;
  logic                    res_ready;
  logic [CNT_WIDTH-1:0]    res_count;
  logic                    res_hit;
  logic [CNT_WIDTH-1:0]    res_first;
  logic                    busy;

  modport master (
    output job_valid, job_target, job_data, job_len, abort, res_ready,
    input  job_ready, res_valid, res_count, res_hit, res_first, busy
  );

  modport slave (
    input  job_valid, job_target, job_data, job_len, abort, res_ready,
    output job_ready, res_valid, res_count, res_hit, res_first, busy
  );
endinterface

// File: rtl/pattern_scan_scheduler_window_matcher.sv
// Bit-serial window matcher: shift window, saturating fill counter and target compare.
module pattern_window_matcher
  import pattern_scan_pkg::*;
#(
  parameter int unsigned TARGET_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load_target,
  input  logic [TARGET_WIDTH-1:0] target,
  input  logic                    shift_en,
  input  logic                    bit_in,
  output logic                    match
);

  localparam int unsigned FILL_WIDTH = $clog2(TARGET_WIDTH + 1);

  logic [TARGET_WIDTH-1:0] window_q, window_d;
  logic [TARGET_WIDTH-1:0] target_q;
  logic [FILL_WIDTH-1:0]   fill_q, fill_d;

  // Match looks at the post-shift window; the fill guard masks the zeroed start-up window.
  always_comb begin
    window_d = {window_q[TARGET_WIDTH-2:0], bit_in};
    fill_d   = (fill_q == FILL_WIDTH'(TARGET_WIDTH)) ? fill_q : fill_q + 1'b1;
    match    = shift_en && (window_d == target_q) &&
               (fill_q >= FILL_WIDTH'(TARGET_WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      window_q <= '0;
      fill_q   <= '0;
      target_q <= '0;
    end else begin
      if (clear) begin
        window_q <= '0;
        fill_q   <= '0;
      end else if (shift_en) begin
        window_q <= window_d;
        fill_q   <= fill_d;
      end
      if (load_target) begin
        target_q <= target;
      end
    end
  end

endmodule

// File: rtl/pattern_scan_scheduler.sv
// Job-level controller: accepts a scan job, streams its bits into the matcher and returns match statistics.
module pattern_scan_scheduler
  import pattern_scan_pkg::*;
#(
  parameter int unsigned TARGET_WIDTH = DEF_TARGET_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH    = $clog2(DATA_WIDTH + 1)
) (
  input logic                     clk,
  input logic                     reset,
  pattern_scan_scheduler_if.slave bus
);

  state_e                state_q;
  logic                  job_ready_q;
  logic                  busy_q;
  logic                  res_valid_q;
  scan_result_t          res_q;
  logic [CNT_WIDTH-1:0]  idx_q;
  logic [CNT_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  accept_c;
  logic                  shift_c;
  logic                  last_c;
  logic                  match_c;
  logic [CNT_WIDTH-1:0]  len_eff_c;

  // Abort wins over a same-cycle job offer in idle.
  always_comb begin
    accept_c  = (state_q == S_IDLE) && bus.job_valid && job_ready_q && !bus.abort;
    shift_c   = (state_q == S_SCAN) && !bus.abort;
    last_c    = (idx_q == CNT_WIDTH'(len_q - 1'b1));
    len_eff_c = (bus.job_len > CNT_WIDTH'(DATA_WIDTH)) ? CNT_WIDTH'(DATA_WIDTH) : bus.job_len;
  end

  pattern_window_matcher #(
    .TARGET_WIDTH(TARGET_WIDTH)
  ) u_matcher (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept_c),
    .load_target(accept_c),
    .target     (bus.job_target),
    .shift_en   (shift_c),
    .bit_in     (data_q[0]),
    .match      (match_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      job_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            data_q      <= bus.job_data;
            idx_q       <= '0;
            len_q       <= len_eff_c;
            res_q       <= '0;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (len_eff_c == '0) begin
              state_q     <= S_DONE;
              res_valid_q <= 1'b1;
            end else begin
              state_q <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (bus.abort) begin
            state_q     <= S_IDLE;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            // Data is consumed LSB first by shifting the latched word.
            data_q <= data_q >> 1;
            idx_q  <= idx_q + 1'b1;
            if (match_c) begin
              res_q.count <= res_q.count + 1'b1;
              if (!res_q.hit) begin
                res_q.hit   <= 1'b1;
                res_q.first <= DEF_CNT_WIDTH'(idx_q);
              end
            end
            if (last_c) begin
              state_q     <= S_DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.res_ready || bus.abort) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          res_valid_q <= 1'b0;
          job_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.job_ready = job_ready_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_count = CNT_WIDTH'(res_q.count);
  assign bus.res_hit   = res_q.hit;
  assign bus.res_first = CNT_WIDTH'(res_q.first);

endmodule
